// File: rtl/pulse_req_arbiter.sv
// Pulse request arbiter: latches one-cycle request pulses and serves them round-robin,
// one command at a time, through a ready/done handshake to a shared memory port.
module pulse_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_pulse,
    output logic                     cmd_valid,
    output logic [$clog2(N_REQ)-1:0] cmd_id,
    input  logic                     cmd_ready,
    input  logic                     done,
    output logic                     busy,
    output logic [N_REQ-1:0]         pending,
    output logic [N_REQ-1:0]         overflow,
    output logic                     timeout_err,
    input  logic                     clr_err
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [ID_W-1:0]  r_grant;
    logic [ID_W-1:0]  r_rrPtr;
    logic [ID_W-1:0]  w_grant;
    logic [ID_W-1:0]  w_rrNext;
    logic [ID_W-1:0]  w_idx;
    logic [CNT_W-1:0] r_waitCnt;
    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] r_overflow;
    logic [N_REQ-1:0] w_clrMask;
    logic [N_REQ-1:0] w_ovfSet;
    logic             r_timeoutErr;
    logic             w_found;
    logic             w_latchGrant;
    logic             w_handshake;
    logic             w_timeout;
    int               w_sum;

    // Round-robin search: first pending bit at or above rr_ptr, wrapping to 0.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(r_rrPtr) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_idx = ID_W'(w_sum);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_latchGrant = 1'b0;
        w_handshake  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_stateNext  = ISSUE;
                    w_latchGrant = 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_handshake = 1'b1;
                    w_stateNext = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    w_stateNext = IDLE;
                end else if (r_waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    w_stateNext = IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign w_rrNext  = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_clrMask = w_handshake ? (N_REQ'(1) << r_grant) : '0;
    // A pulse landing on the bit being cleared is a fresh request, not a lost one.
    assign w_ovfSet  = req_pulse & r_pending & ~w_clrMask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rrPtr      <= '0;
            r_waitCnt    <= '0;
            r_pending    <= '0;
            r_overflow   <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_latchGrant) begin
                r_grant <= w_grant;
            end
            if (w_handshake) begin
                r_rrPtr <= w_rrNext;
            end
            r_waitCnt    <= (r_state == WAIT && w_stateNext == WAIT) ? r_waitCnt + 1'b1 : '0;
            r_pending    <= (r_pending & ~w_clrMask) | req_pulse;
            r_overflow   <= (clr_err ? '0 : r_overflow) | w_ovfSet;
            r_timeoutErr <= (clr_err ? 1'b0 : r_timeoutErr) | w_timeout;
        end
    end

    assign cmd_valid   = (r_state == ISSUE);
    assign cmd_id      = cmd_valid ? r_grant : '0;
    assign busy        = (r_state != IDLE);
    assign pending     = r_pending;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_pulse_req_arbiter.sv
// Self-checking bench for pulse_req_arbiter: scenario tasks with a queue of expected
// grant ids that is checked whenever the arbiter offers a command.
module tb_pulse_req_arbiter;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] req_pulse;
    logic             cmd_valid;
    logic [1:0]       cmd_id;
    logic             cmd_ready;
    logic             done;
    logic             busy;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] overflow;
    logic             timeout_err;
    logic             clr_err;

    int         nChecks = 0;
    int         nBad    = 0;
    logic [1:0] expQ[$];
    logic [1:0] expId;

    pulse_req_arbiter #(
        .N_REQ  (N_REQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_pulse  (req_pulse),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .cmd_ready  (cmd_ready),
        .done       (done),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow),
        .timeout_err(timeout_err),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_pulse = '0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        clr_err   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        nChecks++; if (cmd_valid !== 1'b0) begin nBad++; $display("[TB] FAIL reset_valid: got %0b want 0", cmd_valid); end
        nChecks++; if (cmd_id !== 2'd0) begin nBad++; $display("[TB] FAIL reset_id: got %0d want 0", cmd_id); end
        nChecks++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        nChecks++; if (pending !== 4'b0000) begin nBad++; $display("[TB] FAIL reset_pending: got %b want 0000", pending); end
        nChecks++; if (overflow !== 4'b0000) begin nBad++; $display("[TB] FAIL reset_overflow: got %b want 0000", overflow); end
        nChecks++; if (timeout_err !== 1'b0) begin nBad++; $display("[TB] FAIL reset_timeout: got %0b want 0", timeout_err); end
    endtask

    task automatic test_single();
        do_reset();
        cmd_ready = 1'b1;
        req_pulse = 4'b0001;
        expQ.push_back(2'd0);
        step();
        req_pulse = '0;
        nChecks++; if (pending !== 4'b0001) begin nBad++; $display("[TB] FAIL single_pending: got %b want 0001", pending); end
        nChecks++; if (cmd_valid !== 1'b0) begin nBad++; $display("[TB] FAIL single_early_valid: got %0b want 0", cmd_valid); end
        step();
        nChecks++; if (cmd_valid !== 1'b1) begin nBad++; $display("[TB] FAIL single_valid: got %0b want 1", cmd_valid); end
        nChecks++; if (busy !== 1'b1) begin nBad++; $display("[TB] FAIL single_busy_issue: got %0b want 1", busy); end
        nChecks++;
        if (expQ.size() == 0) begin
            nBad++; $display("[TB] FAIL single_sb: got id %0d, nothing expected", cmd_id);
        end else begin
            expId = expQ.pop_front();
            if (cmd_id !== expId) begin nBad++; $display("[TB] FAIL single_sb: got id %0d want %0d", cmd_id, expId); end
        end
        step();
        nChecks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin nBad++; $display("[TB] FAIL single_wait: got valid=%0b busy=%0b want valid=0 busy=1", cmd_valid, busy); end
        nChecks++; if (cmd_id !== 2'd0) begin nBad++; $display("[TB] FAIL single_id_idle: got %0d want 0", cmd_id); end
        nChecks++; if (pending !== 4'b0000) begin nBad++; $display("[TB] FAIL single_cleared: got %b want 0000", pending); end
        done = 1'b1;
        step();
        done = 1'b0;
        nChecks++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL single_done_idle: got busy=%0b want 0", busy); end
    endtask

    task automatic test_all_four();
        int served;
        int cycles;
        do_reset();
        cmd_ready = 1'b1;
        req_pulse = 4'b1111;
        for (int i = 0; i < 4; i++) expQ.push_back(2'(i));
        step();
        req_pulse = '0;
        nChecks++; if (pending !== 4'b1111) begin nBad++; $display("[TB] FAIL all4_latched: got %b want 1111", pending); end
        served = 0;
        cycles = 0;
        while (served < 4 && cycles < 200) begin
            if (cmd_valid) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nBad++; $display("[TB] FAIL all4_sb: got id %0d, nothing expected", cmd_id);
                end else begin
                    expId = expQ.pop_front();
                    if (cmd_id !== expId) begin nBad++; $display("[TB] FAIL all4_sb: got id %0d want %0d", cmd_id, expId); end
                end
                step();
                step();
                step();
                done = 1'b1;
                step();
                done = 1'b0;
                served++;
            end else begin
                step();
            end
            cycles++;
        end
        nChecks++; if (served != 4) begin nBad++; $display("[TB] FAIL all4_served: got %0d want 4", served); end
        nChecks++; if (pending !== 4'b0000) begin nBad++; $display("[TB] FAIL all4_pending_end: got %b want 0000", pending); end
        nChecks++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL all4_busy_end: got %0b want 0", busy); end
        expQ.delete();
    endtask

    task automatic test_rr_wrap();
        int served;
        int cycles;
        do_reset();
        cmd_ready = 1'b1;
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        step();
        nChecks++; if (cmd_id !== 2'd1) begin nBad++; $display("[TB] FAIL rr_setup_id: got %0d want 1", cmd_id); end
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req_pulse = 4'b0011;
        expQ.push_back(2'd0);
        expQ.push_back(2'd1);
        step();
        req_pulse = '0;
        served = 0;
        cycles = 0;
        while (served < 2 && cycles < 100) begin
            if (cmd_valid) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nBad++; $display("[TB] FAIL rr_sb: got id %0d, nothing expected", cmd_id);
                end else begin
                    expId = expQ.pop_front();
                    if (cmd_id !== expId) begin nBad++; $display("[TB] FAIL rr_sb: got id %0d want %0d", cmd_id, expId); end
                end
                step();
                done = 1'b1;
                step();
                done = 1'b0;
                served++;
            end else begin
                step();
            end
            cycles++;
        end
        nChecks++; if (served != 2) begin nBad++; $display("[TB] FAIL rr_served: got %0d want 2", served); end
        expQ.delete();
    endtask

    task automatic test_overflow();
        do_reset();
        req_pulse = 4'b0011;
        step();
        req_pulse = '0;
        nChecks++; if (pending !== 4'b0011) begin nBad++; $display("[TB] FAIL ovf_latched: got %b want 0011", pending); end
        step();
        nChecks++; if (cmd_valid !== 1'b1 || cmd_id !== 2'd0) begin nBad++; $display("[TB] FAIL ovf_grant: got valid=%0b id=%0d want 1/0", cmd_valid, cmd_id); end
        done      = 1'b1;
        req_pulse = 4'b0010;
        step();
        done      = 1'b0;
        req_pulse = '0;
        nChecks++; if (overflow !== 4'b0010) begin nBad++; $display("[TB] FAIL ovf_set: got %b want 0010", overflow); end
        nChecks++; if (pending !== 4'b0011) begin nBad++; $display("[TB] FAIL ovf_pending_kept: got %b want 0011", pending); end
        nChecks++; if (cmd_valid !== 1'b1 || cmd_id !== 2'd0) begin nBad++; $display("[TB] FAIL ovf_issue_hold: got valid=%0b id=%0d want 1/0", cmd_valid, cmd_id); end
        cmd_ready = 1'b1;
        req_pulse = 4'b0001;
        step();
        cmd_ready = 1'b0;
        req_pulse = '0;
        nChecks++; if (pending !== 4'b0011) begin nBad++; $display("[TB] FAIL ovf_set_wins_pending: got %b want 0011", pending); end
        nChecks++; if (overflow !== 4'b0010) begin nBad++; $display("[TB] FAIL ovf_set_wins_flag: got %b want 0010", overflow); end
        nChecks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin nBad++; $display("[TB] FAIL ovf_wait: got busy=%0b valid=%0b want 1/0", busy, cmd_valid); end
        clr_err   = 1'b1;
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        nChecks++; if (overflow !== 4'b0010) begin nBad++; $display("[TB] FAIL ovf_set_over_clr: got %b want 0010", overflow); end
        step();
        clr_err = 1'b0;
        nChecks++; if (overflow !== 4'b0000) begin nBad++; $display("[TB] FAIL ovf_clr: got %b want 0000", overflow); end
    endtask

    task automatic test_timeout();
        int waitCycles;
        do_reset();
        cmd_ready = 1'b1;
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        step();
        nChecks++; if (cmd_id !== 2'd2) begin nBad++; $display("[TB] FAIL to_grant: got %0d want 2", cmd_id); end
        step();
        nChecks++; if (timeout_err !== 1'b0) begin nBad++; $display("[TB] FAIL to_early_flag: got %0b want 0", timeout_err); end
        waitCycles = 0;
        while (busy && !cmd_valid && waitCycles < 4 * TIMEOUT) begin
            waitCycles++;
            step();
        end
        nChecks++; if (waitCycles != TIMEOUT) begin nBad++; $display("[TB] FAIL to_cycles: got %0d want %0d", waitCycles, TIMEOUT); end
        nChecks++; if (timeout_err !== 1'b1) begin nBad++; $display("[TB] FAIL to_flag: got %0b want 1", timeout_err); end
        nChecks++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL to_idle: got busy=%0b want 0", busy); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        nChecks++; if (timeout_err !== 1'b0) begin nBad++; $display("[TB] FAIL to_clr: got %0b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        req_pulse = 4'b0001;
        step();
        req_pulse = '0;
        step();
        req_pulse = 4'b0001;
        step();
        req_pulse = '0;
        nChecks++; if (cmd_valid !== 1'b1 || overflow !== 4'b0001) begin nBad++; $display("[TB] FAIL rst_mid_setup: got valid=%0b ovf=%b want 1/0001", cmd_valid, overflow); end
        rst_n     = 1'b0;
        req_pulse = 4'b0010;
        step();
        req_pulse = '0;
        nChecks++; if (cmd_valid !== 1'b0 || cmd_id !== 2'd0 || busy !== 1'b0) begin nBad++; $display("[TB] FAIL rst_mid_outputs: got valid=%0b id=%0d busy=%0b want 0/0/0", cmd_valid, cmd_id, busy); end
        nChecks++; if (pending !== 4'b0000 || overflow !== 4'b0000 || timeout_err !== 1'b0) begin nBad++; $display("[TB] FAIL rst_mid_flags: got pend=%b ovf=%b to=%0b want 0000/0000/0", pending, overflow, timeout_err); end
        rst_n = 1'b1;
        step();
        nChecks++; if (busy !== 1'b0 || pending !== 4'b0000) begin nBad++; $display("[TB] FAIL rst_mid_dropped: got busy=%0b pend=%b want 0/0000", busy, pending); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_pulse = '0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        clr_err   = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_rr_wrap();
        test_overflow();
        test_timeout();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/pulse_req_arbiter.md
PULSE_REQ_ARBITER -- requirements
Module: pulse_req_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of pulse requesters, legal range 2..16.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before abort, legal range 2..1023.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; every register SHALL be clocked on the rising edge of clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port req_pulse, input, N_REQ bits: one-cycle request pulses, one bit per requester, sourced from the edge detectors.
REQ-006 The block SHALL have port cmd_valid, output, 1 bit: a command is offered to the shared memory port.
REQ-007 The block SHALL have port cmd_id, output, clog2(N_REQ) bits: index of the granted requester.
REQ-008 The block SHALL have port cmd_ready, input, 1 bit: the memory port accepts the offered command.
REQ-009 The block SHALL have port done, input, 1 bit: one-cycle completion pulse from the memory port.
REQ-010 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-011 The block SHALL have port pending, output, N_REQ bits: latched, unserved requests.
REQ-012 The block SHALL have port overflow, output, N_REQ bits: sticky flag per requester, set when a pulse is lost.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set when WAIT is aborted.
REQ-014 The block SHALL have port clr_err, input, 1 bit: clears overflow and timeout_err.

Function
REQ-015 A req_pulse[i] high at rising edge k SHALL make pending[i] read 1 after edge k.
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-017 In IDLE with pending nonzero at edge k, the FSM SHALL latch grant and go to ISSUE; cmd_valid SHALL be 1 after edge k.
REQ-018 grant SHALL be the first set pending bit found by searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
REQ-019 In ISSUE, cmd_valid SHALL stay 1 and cmd_id SHALL stay equal to grant until the cycle in which cmd_ready is 1.
REQ-020 On the ISSUE handshake edge, the block SHALL clear pending[grant], set rr_ptr to (grant+1) mod N_REQ, deassert cmd_valid and go to WAIT.
REQ-021 In WAIT, done SHALL return the FSM to IDLE on the next edge.
REQ-022 In WAIT, a wait counter SHALL count cycles spent in WAIT and SHALL be zeroed on every entry to WAIT.
REQ-023 If the WAIT cycle count reaches TIMEOUT without done, the FSM SHALL go to IDLE and set timeout_err.
REQ-024 done SHALL be ignored in IDLE and in ISSUE.
REQ-025 cmd_id SHALL be 0 whenever cmd_valid is 0.
REQ-026 busy SHALL be 1 in ISSUE and in WAIT.
REQ-027 If a pulse arrives on requester grant in the same cycle as its handshake clear, the set SHALL win: pending stays 1 and overflow is not set.
REQ-028 A pulse on a requester whose pending bit is already 1 and is not being cleared SHALL set that requester's overflow bit; pending SHALL stay 1.
REQ-029 Simultaneous pulses on several requesters SHALL all be latched in the same cycle.
REQ-030 clr_err SHALL clear overflow and timeout_err on the next edge; a set event in the same cycle SHALL win over clr_err.
REQ-031 The block SHALL issue at most one command at a time and SHALL give the next grant only after WAIT exits.

Reset
REQ-032 While rst_n is 0 at a rising edge, the block SHALL reset: state=IDLE, pending=0, overflow=0, timeout_err=0, rr_ptr=0, wait counter=0, cmd_valid=0, cmd_id=0, busy=0.
REQ-033 Reset applied mid-ISSUE or mid-WAIT SHALL abandon the command with no done handling, and pulses in the reset cycle SHALL be dropped.

Verification
REQ-034 The bench SHALL cover: req_pulse=0001 at edge k with cmd_ready tied 1 -> cmd_valid=1 and cmd_id=0 after edge k+1; WAIT entered after edge k+2; done then returns to IDLE.
REQ-035 The bench SHALL cover: req_pulse=1111 in one cycle with done three cycles after each handshake -> cmd_id order 0,1,2,3 and pending=0000 at the end.
REQ-036 The bench SHALL cover: rr_ptr=2 with pending=0011 -> grant order 0 then 1.
REQ-037 The bench SHALL cover: a second pulse on requester 1 while pending[1]=1 during another grant -> overflow=0010; clr_err -> overflow=0000.
REQ-038 The bench SHALL cover: done withheld in WAIT with TIMEOUT=16 -> IDLE after 16 WAIT cycles and timeout_err=1.
REQ-039 The bench SHALL cover: rst_n=0 asserted during ISSUE -> all outputs 0 and busy=0 after the next edge.
